pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, one-cycle flush with
// redirect PC, and a free-running count of stalled cycles.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stallreq_i,
    input  logic        ex_stallreq_i,
    input  logic        mem_stallreq_i,
    input  logic        exc_flag_i,
    input  logic [31:0] exc_target_i,
    input  logic        cnt_clr_i,
    output logic [4:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] flush_pc_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [4:0] StallNone = 5'b00000;
    localparam logic [4:0] StallId   = 5'b00011;
    localparam logic [4:0] StallEx   = 5'b00111;
    localparam logic [4:0] StallMem  = 5'b01111;
    localparam logic [4:0] StallAll  = 5'b11111;

    typedef enum logic [1:0] {StRun, StExcWait, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            target_q    <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Only RUN accepts an exception, so the first one's target is never overwritten.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            StRun: begin
                if (exc_flag_i) begin
                    target_d = exc_target_i;
                    state_d  = mem_stallreq_i ? StExcWait : StFlush;
                end
            end
            StExcWait: begin
                if (!mem_stallreq_i) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall_o    = StallNone;
        flush_o    = 1'b0;
        flush_pc_o = 32'h0;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    if (exc_flag_i) begin
                        stall_o = mem_stallreq_i ? StallMem : StallAll;
                    end else if (mem_stallreq_i) begin
                        stall_o = StallMem;
                    end else if (ex_stallreq_i) begin
                        stall_o = StallEx;
                    end else if (id_stallreq_i) begin
                        stall_o = StallId;
                    end
                end
                StExcWait: stall_o = mem_stallreq_i ? StallMem : StallAll;
                StFlush: begin
                    flush_o    = 1'b1;
                    flush_pc_o = target_q;
                end
                default: stall_o = StallNone;
            endcase
        end
    end

    // Clear wins over increment; the counter wraps naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = 32'h0;
        end else if (stall_o != StallNone) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model compared every cycle plus
// directed scenarios with literal expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_req = 1'b0;
    logic        ex_req = 1'b0;
    logic        mem_req = 1'b0;
    logic        exc = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        clr = 1'b0;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a pending redirect is either waiting for MEM or due next cycle.
    bit          m_wait  = 1'b0;
    bit          m_flush = 1'b0;
    logic [31:0] m_tgt   = 32'h0;
    logic [31:0] m_cnt   = 32'h0;
    logic [4:0]  m_s;
    bit          chk_en  = 1'b0;
    logic        preload = 1'b0;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_stallreq_i  (id_req),
        .ex_stallreq_i  (ex_req),
        .mem_stallreq_i (mem_req),
        .exc_flag_i     (exc),
        .exc_target_i   (tgt),
        .cnt_clr_i      (clr),
        .stall_o        (stall),
        .flush_o        (flush),
        .flush_pc_o     (flush_pc),
        .stall_cnt_o    (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model_stall();
        if (rst || m_flush) return 5'b00000;
        if (m_wait || exc) return mem_req ? 5'b01111 : 5'b11111;
        if (mem_req) return 5'b01111;
        if (ex_req) return 5'b00111;
        if (id_req) return 5'b00011;
        return 5'b00000;
    endfunction

    always @(posedge clk or posedge rst or posedge preload) begin
        if (rst) begin
            m_wait  = 1'b0;
            m_flush = 1'b0;
            m_tgt   = 32'h0;
            m_cnt   = 32'h0;
        end else if (preload) begin
            m_cnt = 32'hFFFF_FFFF;
        end else begin
            m_s = model_stall();
            if (clr) m_cnt = 32'h0;
            else if (m_s != 5'b00000) m_cnt = m_cnt + 32'd1;
            if (m_flush) begin
                m_flush = 1'b0;
            end else if (m_wait) begin
                if (!mem_req) begin
                    m_wait  = 1'b0;
                    m_flush = 1'b1;
                end
            end else if (exc) begin
                m_tgt = tgt;
                if (mem_req) m_wait = 1'b1;
                else m_flush = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_stall", {27'h0, stall}, {27'h0, model_stall()});
            check("model_flush", {31'h0, flush}, {31'h0, m_flush});
            check("model_flush_pc", flush_pc, m_flush ? m_tgt : 32'h0);
            check("model_stall_cnt", cnt, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // Requests active during reset must not stall.
        id_req  = 1'b1;
        mem_req = 1'b1;
        chk_en  = 1'b1;
        smp();
        check("rst_stall", {27'h0, stall}, 32'h0);
        check("rst_cnt", cnt, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        @(posedge clk);
        #2;
        id_req  = 1'b0;
        mem_req = 1'b0;
        #1 rst = 1'b0;

        // Stall priority
        cyc(); id_req = 1'b1; ex_req = 1'b1;
        smp(); check("prio_ex", {27'h0, stall}, 32'h07);
        cyc(); mem_req = 1'b1;
        smp(); check("prio_mem", {27'h0, stall}, 32'h0F);
        cyc(); id_req = 1'b0; ex_req = 1'b0; mem_req = 1'b0;
        smp(); check("prio_none", {27'h0, stall}, 32'h00);
        check("prio_cnt", cnt, 32'd2);

        // Immediate exception
        cyc(); exc = 1'b1; tgt = 32'hBFC0_0380;
        smp(); check("imm_stall", {27'h0, stall}, 32'h1F);
        cyc(); exc = 1'b0; tgt = 32'h0;
        smp(); check("imm_flush", {31'h0, flush}, 32'h1);
        check("imm_flush_pc", flush_pc, 32'hBFC0_0380);
        check("imm_flush_stall", {27'h0, stall}, 32'h00);
        cyc();
        smp(); check("imm_flush_end", {31'h0, flush}, 32'h0);
        check("imm_pc_end", flush_pc, 32'h0);

        // Deferred exception, with a second exception while waiting
        cyc(); mem_req = 1'b1; exc = 1'b1; tgt = 32'hBFC0_0200;
        smp(); check("def_c1", {27'h0, stall}, 32'h0F);
        cyc(); tgt = 32'h8000_0180;
        smp(); check("def_c2", {27'h0, stall}, 32'h0F);
        cyc(); exc = 1'b0; tgt = 32'h0;
        smp(); check("def_c3", {27'h0, stall}, 32'h0F);
        cyc(); mem_req = 1'b0;
        smp(); check("def_c4", {27'h0, stall}, 32'h1F);
        check("def_c4_flush", {31'h0, flush}, 32'h0);
        cyc();
        smp(); check("def_c5_flush", {31'h0, flush}, 32'h1);
        check("def_first_wins", flush_pc, 32'hBFC0_0200);
        cyc();
        smp(); check("def_c6_flush", {31'h0, flush}, 32'h0);

        // Counter wrap via preload, then clear priority
        cyc();
        chk_en = 1'b0;
        #1 force dut.stall_cnt_q = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1 release dut.stall_cnt_q;
        preload = 1'b0;
        chk_en = 1'b1;
        smp(); check("cnt_preload", cnt, 32'hFFFF_FFFF);
        cyc(); id_req = 1'b1;
        smp(); check("cnt_pre_wrap", cnt, 32'hFFFF_FFFF);
        cyc(); id_req = 1'b0;
        smp(); check("cnt_wrap", cnt, 32'h0);
        cyc(); id_req = 1'b1;
        cyc();
        cyc(); clr = 1'b1;
        smp(); check("clr_stall_active", {27'h0, stall}, 32'h03);
        check("clr_cnt_before", cnt, 32'd2);
        cyc(); clr = 1'b0; id_req = 1'b0;
        smp(); check("clr_prio", cnt, 32'h0);

        // Reset while waiting for MEM aborts the redirect
        cyc(); mem_req = 1'b1; exc = 1'b1; tgt = 32'hBFC0_0380;
        cyc(); exc = 1'b0; tgt = 32'h0;
        smp(); check("rw_cnt_nonzero", {31'h0, cnt != 32'h0}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rw_async_flush", {31'h0, flush}, 32'h0);
        check("rw_async_cnt", cnt, 32'h0);
        check("rw_async_stall", {27'h0, stall}, 32'h0);
        cyc(); mem_req = 1'b0;
        cyc();
        #2 rst = 1'b0;
        cyc();
        smp(); check("rw_no_flush1", {31'h0, flush}, 32'h0);
        cyc();
        smp(); check("rw_no_flush2", {31'h0, flush}, 32'h0);
        check("rw_no_stall", {27'h0, stall}, 32'h0);
        cyc();
        smp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
